// File: rtl/sobel_frame_writer.sv
// Sobel output stage: thresholds interior gradient magnitudes into a 1-bit frame
// buffer, then streams the full frame with zeroed borders as 0/255 pixels.
module sobel_frame_writer #(
  parameter int ROW_SIZE  = 8,
  parameter int COL_SIZE  = 8,
  parameter int THRESHOLD = 100,
  parameter int MAG_WIDTH = 11,
  parameter int CNT_WIDTH = $clog2(ROW_SIZE*COL_SIZE+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [MAG_WIDTH-1:0] mag_i,
  input  logic                 mag_valid_i,
  output logic                 mag_ready_o,
  output logic [7:0]           pix_o,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i,
  output logic                 pix_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] edge_count_o,
  output logic [1:0]           state_o
);
  // Handshakes: a beat transfers on the rising edge where valid && ready are both
  // high; a source holds its payload and valid stable until that edge.

  localparam int NPIX = ROW_SIZE * COL_SIZE;
  localparam int KW   = $clog2(NPIX);
  localparam int RW   = $clog2(ROW_SIZE);
  localparam int CW   = $clog2(COL_SIZE);

  localparam logic [RW-1:0] R_IN_LAST = RW'(ROW_SIZE - 3);
  localparam logic [CW-1:0] C_IN_LAST = CW'(COL_SIZE - 3);
  localparam logic [RW-1:0] R_LAST    = RW'(ROW_SIZE - 1);
  localparam logic [CW-1:0] C_LAST    = CW'(COL_SIZE - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        r_q, dr_q;
  logic [CW-1:0]        c_q, dc_q;
  logic [KW-1:0]        k_q;
  logic                 mag_ready_q, pix_valid_q, done_q;
  logic [CNT_WIDTH-1:0] edge_cnt_q;
  logic [NPIX-1:0]      frame_q;

  logic          xfer, fill_last, hs, drain_last, edge_bit, interior, start_ok;
  logic [KW-1:0] wr_idx;

  assign start_ok   = (state_q == IDLE) && start_i;
  assign xfer       = (state_q == FILL) && mag_valid_i && mag_ready_q;
  assign fill_last  = xfer && (r_q == R_IN_LAST) && (c_q == C_IN_LAST);
  assign hs         = (state_q == DRAIN) && pix_valid_q && pix_ready_i;
  assign drain_last = hs && (k_q == K_LAST);
  assign edge_bit   = mag_i > MAG_WIDTH'(THRESHOLD);
  // Interior (r, c) lands at frame position (r+1, c+1), leaving a one-cell border.
  assign wr_idx     = (KW'(r_q) + KW'(1)) * KW'(COL_SIZE) + KW'(c_q) + KW'(1);
  assign interior   = (dr_q != '0) && (dr_q != R_LAST) && (dc_q != '0) && (dc_q != C_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)    state_d = FILL;
      FILL:    if (fill_last)  state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != IDLE);
    state_o      = state_q;
    mag_ready_o  = mag_ready_q;
    pix_valid_o  = pix_valid_q;
    done_o       = done_q;
    edge_count_o = edge_cnt_q;
    // Buffer is register-based, so the pixel is read combinationally from k_q.
    pix_o        = (pix_valid_q && interior && frame_q[k_q]) ? 8'd255 : 8'd0;
    pix_last_o   = pix_valid_q && (k_q == K_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q         <= '0;
      c_q         <= '0;
      dr_q        <= '0;
      dc_q        <= '0;
      k_q         <= '0;
      mag_ready_q <= 1'b0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
      edge_cnt_q  <= '0;
    end else begin
      mag_ready_q <= (state_q == FILL) && !fill_last;
      pix_valid_q <= (state_q == DRAIN) && !drain_last;
      done_q      <= drain_last;
      if (start_ok) begin
        r_q        <= '0;
        c_q        <= '0;
        dr_q       <= '0;
        dc_q       <= '0;
        k_q        <= '0;
        edge_cnt_q <= '0;
      end
      if (xfer) begin
        if (edge_bit) edge_cnt_q <= edge_cnt_q + CNT_WIDTH'(1);
        if (c_q == C_IN_LAST) begin
          c_q <= '0;
          r_q <= r_q + RW'(1);
        end else begin
          c_q <= c_q + CW'(1);
        end
      end
      if (hs) begin
        k_q <= k_q + KW'(1);
        if (dc_q == C_LAST) begin
          dc_q <= '0;
          dr_q <= dr_q + RW'(1);
        end else begin
          dc_q <= dc_q + CW'(1);
        end
      end
    end
  end

  // Frame storage is deliberately not reset; every interior cell is rewritten per frame.
  always_ff @(posedge clk_i) begin
    if (xfer) frame_q[wr_idx] <= edge_bit;
  end

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Directed bench for sobel_frame_writer: threshold edge, all-max, backpressure,
// overrun/ignored start, and reset in the middle of a frame.
module tb_sobel_frame_writer;
  localparam int R    = 8;
  localparam int C    = 8;
  localparam int TH   = 100;
  localparam int MW   = 11;
  localparam int CNTW = $clog2(R*C+1);
  localparam int NINT = (R-2)*(C-2);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [MW-1:0]   mag;
  logic            mag_valid;
  logic            mag_ready;
  logic [7:0]      pix;
  logic            pix_valid;
  logic            pix_ready;
  logic            pix_last;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] edge_count;
  logic [1:0]      state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int exp_edges;

  always #5 clk = ~clk;

  sobel_frame_writer #(
    .ROW_SIZE(R), .COL_SIZE(C), .THRESHOLD(TH), .MAG_WIDTH(MW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .mag_i(mag), .mag_valid_i(mag_valid), .mag_ready_o(mag_ready),
    .pix_o(pix), .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
    .pix_last_o(pix_last), .busy_o(busy), .done_o(done),
    .edge_count_o(edge_count), .state_o(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] mag_val(input int mode, input int i);
    case (mode)
      0:       return (i % 2 == 1) ? 11'd101 : 11'd100;
      1:       return 11'd2040;
      2:       return 11'd0;
      default: return MW'((i * 53 + 7) % 200 + 1);
    endcase
  endfunction

  task automatic build_exp(input int mode);
    int r, c;
    exp_q.delete();
    exp_edges = 0;
    for (int i = 0; i < NINT; i++) if (mag_val(mode, i) > MW'(TH)) exp_edges++;
    for (int k = 0; k < R*C; k++) begin
      r = k / C;
      c = k % C;
      if (r > 0 && r < R-1 && c > 0 && c < C-1 && mag_val(mode, (r-1)*(C-2) + (c-1)) > MW'(TH))
        exp_q.push_back(8'd255);
      else
        exp_q.push_back(8'd0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_fill(input int mode, input bit rnd_valid, input int stop_after,
                         input int extra_hold, input int start_at);
    int cyc = 0;
    int accepted = 0;
    int extra_acc = 0;
    while (accepted < stop_after && cyc < 1000) begin
      mag_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      mag       = mag_val(mode, accepted);
      start     = (accepted == start_at);
      if (mag_valid && mag_ready) accepted++;
      tick();
      cyc++;
    end
    start = 1'b0;
    check("fill_accepted", 32'(accepted), 32'(stop_after));
    for (int i = 0; i < extra_hold; i++) begin
      mag_valid = 1'b1;
      mag       = mag_val(mode, accepted + i);
      if (mag_ready) extra_acc++;
      tick();
    end
    mag_valid = 1'b0;
    if (extra_hold > 0) check("overrun_accept", 32'(extra_acc), 32'd0);
  endtask

  task automatic do_drain(input bit rnd_ready, input int start_at, input bit no_gap);
    int k = 0, cyc = 0, gaps = 0;
    int done_early = 0, last_bad = 0, ready_bad = 0, unstable = 0;
    bit started = 0, holding = 0;
    logic [7:0] held;
    logic held_last;
    logic [7:0] e;
    while (k < R*C && cyc < 2000) begin
      pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = (k == start_at);
      if (holding && (pix !== held || pix_valid !== 1'b1 || pix_last !== held_last)) unstable++;
      if (done) done_early++;
      if (mag_ready) ready_bad++;
      if (pix_valid) begin
        started = 1;
        if (pix_ready) begin
          e = exp_q.pop_front();
          check($sformatf("pix_k%0d", k), 32'(pix), 32'(e));
          if (pix_last !== (k == R*C-1)) last_bad++;
          k++;
          holding = 0;
        end else begin
          holding   = 1;
          held      = pix;
          held_last = pix_last;
        end
      end else if (started) begin
        gaps++;
      end
      tick();
      cyc++;
    end
    start     = 1'b0;
    pix_ready = 1'b0;
    check("drain_count", 32'(k), 32'(R*C));
    check("done_pulse", 32'(done), 32'd1);
    check("valid_after_last", 32'(pix_valid), 32'd0);
    check("idle_after_last", 32'(busy), 32'd0);
    check("last_flag_errs", 32'(last_bad), 32'd0);
    check("stall_unstable", 32'(unstable), 32'd0);
    check("done_early", 32'(done_early), 32'd0);
    check("ready_in_drain", 32'(ready_bad), 32'd0);
    check("edge_count", 32'(edge_count), 32'(exp_edges));
    if (no_gap) check("valid_gaps", 32'(gaps), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("edge_count_hold", 32'(edge_count), 32'(exp_edges));
  endtask

  initial begin
    int bad;
    rst_n     = 1'b0;
    start     = 1'b0;
    mag       = '0;
    mag_valid = 1'b0;
    pix_ready = 1'b0;

    // Reset then idle
    #22;
    check("rst_ready", 32'(mag_ready), 32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_last", 32'(pix_last), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(edge_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      mag_valid = 1'(i % 2);
      if (mag_ready || busy || pix_valid || done) bad++;
      tick();
    end
    mag_valid = 1'b0;
    check("idle_20_cycles", 32'(bad), 32'd0);

    // Threshold edge: 100 -> 0, 101 -> 255
    build_exp(0);
    check("thr_model_edges", 32'(exp_edges), 32'd18);
    do_start();
    do_fill(0, 0, NINT, 0, -1);
    check("thr_count_after_fill", 32'(edge_count), 32'd18);
    check("thr_state_drain", 32'(state_dbg), 32'd2);
    do_drain(0, -1, 1);

    // All-max frame at full throughput
    tick();
    build_exp(1);
    do_start();
    do_fill(1, 0, NINT, 0, -1);
    do_drain(0, -1, 1);
    check("max_edges", 32'(edge_count), 32'd36);

    // Mixed pattern without then with stalls on both sides
    tick();
    build_exp(3);
    do_start();
    do_fill(3, 0, NINT, 0, -1);
    do_drain(0, -1, 1);
    tick();
    build_exp(3);
    do_start();
    do_fill(3, 1, NINT, 0, -1);
    do_drain(1, -1, 0);

    // Overrun with start pulses in FILL and DRAIN
    tick();
    build_exp(0);
    do_start();
    do_fill(0, 0, NINT, 4, 10);
    do_drain(0, 5, 1);

    // Reset mid-FILL
    tick();
    do_start();
    do_fill(1, 0, 20, 0, -1);
    check("mid_count", 32'(edge_count), 32'd20);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(mag_ready), 32'd0);
    check("abort_valid", 32'(pix_valid), 32'd0);
    check("abort_count", 32'(edge_count), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) bad++;
      tick();
    end
    check("abort_no_done", 32'(bad), 32'd0);
    build_exp(2);
    do_start();
    do_fill(2, 0, NINT, 0, -1);
    do_drain(0, -1, 1);
    check("zero_edges", 32'(edge_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
